// File: rtl/uart_cmd_framer.sv
// Builds 2-byte little-endian orders from the UART byte stream and validates them.
// Accepted orders are queued in a FWFT FIFO and handed to the sequencer via valid/ready.
module uart_cmd_framer #(
  parameter int TIMEOUT_CYCLES = 500000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  output logic [15:0]                   cmd_data,
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          timeout_pulse,
  output logic                          reject_pulse,
  output logic                          drop_pulse
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] FULL   = CW'(FIFO_DEPTH);

  typedef enum logic {S_BYTE1, S_BYTE2} state_t;

  state_t        state;
  logic [7:0]    low_byte;
  logic [TW-1:0] timer;
  logic [15:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;

  logic [15:0] frame;
  logic        frame_done, frame_ok, room, push, pop;

  assign frame      = {rx_data, low_byte};
  assign frame_done = (state == S_BYTE2) && rx_valid;
  assign frame_ok   = frame[15] && (frame[14:0] != 15'd0);
  assign pop        = cmd_valid && cmd_ready;
  // A full FIFO still takes the new order when the head leaves in the same cycle.
  assign room       = (fifo_count != FULL) || pop;
  assign push       = frame_done && frame_ok && room;

  assign cmd_valid  = (fifo_count != '0);
  assign cmd_data   = cmd_valid ? mem[rd_ptr] : 16'h0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_BYTE1;
      low_byte      <= '0;
      timer         <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      fifo_count    <= '0;
      timeout_pulse <= 1'b0;
      reject_pulse  <= 1'b0;
      drop_pulse    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      timeout_pulse <= 1'b0;
      reject_pulse  <= 1'b0;
      drop_pulse    <= 1'b0;
      case (state)
        S_BYTE1: if (rx_valid) begin
          low_byte <= rx_data;
          timer    <= '0;
          state    <= S_BYTE2;
        end
        S_BYTE2: begin
          // rx_valid takes priority over an expiring timer
          if (rx_valid) begin
            state        <= S_BYTE1;
            reject_pulse <= !frame_ok;
            drop_pulse   <= frame_ok && !room;
          end else if (timer == T_LAST) begin
            timeout_pulse <= 1'b1;
            low_byte      <= '0;
            state         <= S_BYTE1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= S_BYTE1;
      endcase

      if (push) begin
        mem[wr_ptr] <= frame;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
    end
  end
endmodule
